regfile_mp: RTL and testbench

//  Parametrised next-generation GPR file for the pipeline's decode and writeback stages.

---
 rtl/regfile_mp.sv | 152 +++++++++++++++
 tb/tb_regfile_mp.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port general-purpose register file with load extension, link write,
// HI/LO registers, write-through bypass and a post-reset clearing sequencer.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int LINK_REG = 31
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NRD*ADDR_W-1:0]   rd_addr_i,
  output logic [NRD*DATA_W-1:0]   rd_data_o,
  input  logic                    we_i,
  input  logic [ADDR_W-1:0]       wa_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic [2:0]              ld_mode_i,
  input  logic [1:0]              ld_off_i,
  input  logic                    link_we_i,
  input  logic [DATA_W-3:0]       link_pc_i,
  input  logic                    hilo_we_i,
  input  logic [2*DATA_W-1:0]     hilo_data_i,
  input  logic                    hi_we_i,
  input  logic                    lo_we_i,
  output logic [DATA_W-1:0]       hi_out_o,
  output logic [DATA_W-1:0]       lo_out_o,
  output logic                    init_busy_o
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int PAD_W = (DATA_W < 32) ? 32 : DATA_W;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] regs_q [NREGS];

  logic              ready;
  logic              gprWe;
  logic              linkWe;
  logic [DATA_W-1:0] linkVal;
  logic [PAD_W-1:0]  wPad;
  logic [7:0]        laneB;
  logic [15:0]       laneH;
  logic [DATA_W-1:0] extVal;

  assign ready   = (state_q == ST_READY);
  assign gprWe   = ready && we_i && (wa_i != '0);
  assign linkWe  = ready && link_we_i && (LINK_ADDR != '0);
  assign linkVal = {link_pc_i, 2'b00};

  // Zero-padding keeps every byte lane selectable even for 16-bit builds.
  assign wPad = PAD_W'(wdata_i);

  always_comb begin
    laneB = wPad[7:0];
    case (ld_off_i)
      2'd1:    laneB = wPad[15:8];
      2'd2:    laneB = wPad[23:16];
      2'd3:    laneB = wPad[31:24];
      default: laneB = wPad[7:0];
    endcase
    laneH = ld_off_i[1] ? wPad[31:16] : wPad[15:0];
  end

  always_comb begin
    extVal = wdata_i;
    case (ld_mode_i)
      3'b001:  extVal = {{(DATA_W-8){laneB[7]}}, laneB};
      3'b010:  extVal = {{(DATA_W-8){1'b0}}, laneB};
      3'b011:  extVal = {{(DATA_W-16){laneH[15]}}, laneH};
      3'b100:  extVal = {{(DATA_W-16){1'b0}}, laneH};
      default: extVal = wdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d = ST_READY;
      end
    end else begin
      // Whole-pair load first so MTHI/MTLO can override their own half.
      if (hilo_we_i) begin
        hi_d = hilo_data_i[2*DATA_W-1:DATA_W];
        lo_d = hilo_data_i[DATA_W-1:0];
      end
      if (hi_we_i) hi_d = wdata_i;
      if (lo_we_i) lo_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // The link write is issued last so it wins a same-edge collision with we.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == ST_INIT) begin
        regs_q[cnt_q] <= '0;
      end else begin
        if (gprWe)  regs_q[wa_i]      <= extVal;
        if (linkWe) regs_q[LINK_ADDR] <= linkVal;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdVal;

    assign ra = rd_addr_i[k*ADDR_W +: ADDR_W];

    always_comb begin
      rdVal = regs_q[ra];
      if (!ready || (ra == '0)) begin
        rdVal = '0;
      end else if (linkWe && (ra == LINK_ADDR)) begin
        rdVal = linkVal;
      end else if (gprWe && (ra == wa_i)) begin
        rdVal = extVal;
      end
    end

    assign rd_data_o[k*DATA_W +: DATA_W] = rdVal;
  end

  assign hi_out_o    = hi_q;
  assign lo_out_o    = lo_q;
  assign init_busy_o = (state_q == ST_INIT);

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// checked against a behavioural register-file model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rdAddr;
  logic [63:0] rdData;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wdata;
  logic [2:0]  ldMode;
  logic [1:0]  ldOff;
  logic        linkWe;
  logic [29:0] linkPc;
  logic        hiloWe;
  logic [63:0] hiloData;
  logic        hiWe;
  logic        loWe;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic        initBusy;

  int checks = 0;
  int errors = 0;

  // Behavioural model: register array, HI/LO and edges left in the clearing phase.
  logic [31:0] regM [32];
  logic [31:0] hiM;
  logic [31:0] loM;
  int          busyCnt = 0;

  regfile_mp dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rd_addr_i   (rdAddr),
    .rd_data_o   (rdData),
    .we_i        (we),
    .wa_i        (wa),
    .wdata_i     (wdata),
    .ld_mode_i   (ldMode),
    .ld_off_i    (ldOff),
    .link_we_i   (linkWe),
    .link_pc_i   (linkPc),
    .hilo_we_i   (hiloWe),
    .hilo_data_i (hiloData),
    .hi_we_i     (hiWe),
    .lo_we_i     (loWe),
    .hi_out_o    (hiOut),
    .lo_out_o    (loOut),
    .init_busy_o (initBusy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refExt(logic [31:0] w, logic [2:0] m, logic [1:0] off);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (m)
      3'd1:    return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] refRead(logic [4:0] a);
    if (busyCnt > 0) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (linkWe && a == 5'd31) return {linkPc, 2'b00};
    if (we && wa == a) return refExt(wdata, ldMode, ldOff);
    return regM[a];
  endfunction

  task automatic clearInputs();
    rst = 1'b0; rdAddr = '0; we = 1'b0; wa = '0; wdata = '0; ldMode = '0; ldOff = '0;
    linkWe = 1'b0; linkPc = '0; hiloWe = 1'b0; hiloData = '0; hiWe = 1'b0; loWe = 1'b0;
  endtask

  // Advance the model by one edge from the current inputs, then let the DUT take the edge.
  task automatic tick();
    if (rst) begin
      busyCnt = 32;
      hiM = 32'h0;
      loM = 32'h0;
    end else if (busyCnt > 0) begin
      regM[32 - busyCnt] = 32'h0;
      busyCnt--;
    end else begin
      if (we && wa != 5'd0) regM[wa] = refExt(wdata, ldMode, ldOff);
      if (linkWe) regM[31] = {linkPc, 2'b00};
      if (hiloWe) begin
        hiM = hiloData[63:32];
        loM = hiloData[31:0];
      end
      if (hiWe) hiM = wdata;
      if (loWe) loM = wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clearInputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (initBusy !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_busy got %b want 1", initBusy);
    end
    checks++;
    if (hiOut !== 32'h0 || loOut !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_hilo got %h/%h want 0/0", hiOut, loOut);
    end
    rst = 1'b0;
    we = 1'b1; wa = 5'd9; wdata = 32'hCAFE_F00D; hiWe = 1'b1; linkWe = 1'b1; linkPc = 30'h123;
    for (int i = 0; i < 32; i++) begin
      rdAddr = {5'd31, 5'(i)};
      #1;
      checks++;
      if (initBusy !== 1'b1 || rdData !== 64'h0) begin
        errors++; $display("[TB] FAIL init_phase edge %0d got busy=%b data=%h want busy=1 data=0", i, initBusy, rdData);
      end
      tick();
    end
    checks++;
    if (initBusy !== 1'b0) begin
      errors++; $display("[TB] FAIL init_done got %b want 0", initBusy);
    end
    checks++;
    if (hiOut !== 32'h0) begin
      errors++; $display("[TB] FAIL init_ignores_hi got %h want 0", hiOut);
    end
    clearInputs();
    for (int a = 0; a < 32; a++) begin
      rdAddr = {5'(31 - a), 5'(a)};
      #1;
      checks++;
      if (rdData !== 64'h0) begin
        errors++; $display("[TB] FAIL cleared_reg %0d got %h want 0", a, rdData);
      end
    end
  endtask

  task automatic test_extension();
    logic [2:0]  modes [3] = '{3'b001, 3'b100, 3'b011};
    logic [1:0]  offs  [3] = '{2'd3, 2'd3, 2'd0};
    logic [31:0] wants [3] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'h0000_7F01};
    for (int i = 0; i < 3; i++) begin
      clearInputs();
      we = 1'b1; wa = 5'd5; wdata = 32'h80FF_7F01; ldMode = modes[i]; ldOff = offs[i];
      tick();
      clearInputs();
      rdAddr = {5'd0, 5'd5};
      #1;
      checks++;
      if (rdData[31:0] !== wants[i]) begin
        errors++; $display("[TB] FAIL extension mode=%b off=%0d got %h want %h", modes[i], offs[i], rdData[31:0], wants[i]);
      end
    end
  endtask

  task automatic test_bypass();
    clearInputs();
    we = 1'b1; wa = 5'd7; wdata = 32'h1234_5678; rdAddr = {5'd0, 5'd7};
    #1;
    checks++;
    if (rdData[31:0] !== 32'h1234_5678) begin
      errors++; $display("[TB] FAIL bypass got %h want 12345678", rdData[31:0]);
    end
    tick();
    wa = 5'd0; wdata = 32'hFFFF_FFFF; rdAddr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rdData[31:0] !== 32'h0) begin
      errors++; $display("[TB] FAIL zero_bypass got %h want 0", rdData[31:0]);
    end
    tick();
    clearInputs();
    rdAddr = {5'd7, 5'd0};
    #1;
    checks++;
    if (rdData !== {32'h1234_5678, 32'h0}) begin
      errors++; $display("[TB] FAIL zero_and_r7 got %h want 12345678_00000000", rdData);
    end
  endtask

  task automatic test_link_conflict();
    clearInputs();
    we = 1'b1; wa = 5'd31; wdata = 32'hAAAA_AAAA; linkWe = 1'b1; linkPc = 30'h0000_0040;
    rdAddr = {5'd0, 5'd31};
    #1;
    checks++;
    if (rdData[31:0] !== 32'h0000_0100) begin
      errors++; $display("[TB] FAIL link_bypass got %h want 00000100", rdData[31:0]);
    end
    tick();
    clearInputs();
    rdAddr = {5'd31, 5'd0};
    #1;
    checks++;
    if (rdData[63:32] !== 32'h0000_0100) begin
      errors++; $display("[TB] FAIL link_conflict got %h want 00000100", rdData[63:32]);
    end
  endtask

  task automatic test_hilo();
    clearInputs();
    hiloWe = 1'b1; hiloData = 64'h1111_2222_3333_4444; loWe = 1'b1; wdata = 32'h5;
    #1;
    checks++;
    if (hiOut !== hiM) begin
      errors++; $display("[TB] FAIL hi_no_bypass got %h want %h", hiOut, hiM);
    end
    tick();
    clearInputs();
    checks++;
    if (hiOut !== 32'h1111_2222 || loOut !== 32'h0000_0005) begin
      errors++; $display("[TB] FAIL hilo_priority got %h/%h want 11112222/00000005", hiOut, loOut);
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      clearInputs();
      we       = ($urandom_range(0, 3) != 0);
      wa       = 5'($urandom_range(0, 31));
      wdata    = $urandom;
      ldMode   = 3'($urandom_range(0, 7));
      ldOff    = 2'($urandom_range(0, 3));
      linkWe   = ($urandom_range(0, 7) == 0);
      linkPc   = 30'($urandom);
      hiloWe   = ($urandom_range(0, 5) == 0);
      hiloData = {$urandom, $urandom};
      hiWe     = ($urandom_range(0, 7) == 0);
      loWe     = ($urandom_range(0, 7) == 0);
      rdAddr   = {($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31))};
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rdData[k*32 +: 32] !== refRead(rdAddr[k*5 +: 5])) begin
          errors++;
          $display("[TB] FAIL random_rd%0d iter %0d addr %0d got %h want %h", k, i, rdAddr[k*5 +: 5], rdData[k*32 +: 32], refRead(rdAddr[k*5 +: 5]));
        end
      end
      checks++;
      if (hiOut !== hiM || loOut !== loM) begin
        errors++; $display("[TB] FAIL random_hilo iter %0d got %h/%h want %h/%h", i, hiOut, loOut, hiM, loM);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_init();
    clearInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1; we = 1'b1; wa = 5'd3; wdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (initBusy !== 1'b1) begin
        errors++; $display("[TB] FAIL midinit_busy edge %0d got %b want 1", i, initBusy);
      end
      tick();
    end
    checks++;
    if (initBusy !== 1'b0) begin
      errors++; $display("[TB] FAIL midinit_done got %b want 0", initBusy);
    end
    clearInputs();
    rdAddr = {5'd0, 5'd3};
    #1;
    checks++;
    if (rdData[31:0] !== 32'h0) begin
      errors++; $display("[TB] FAIL midinit_write_ignored got %h want 0", rdData[31:0]);
    end
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_extension();
    test_bypass();
    test_link_conflict();
    test_hilo();
    test_random(300);
    test_reset_mid_init();
    test_random(100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
